m_mem_arbiter: RTL and testbench

M_MEM_ARBITER -- requirements
Module: m_mem_arbiter

---
 rtl/m_mem_arbiter_pkg.sv | 28 ++
 rtl/m_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_m_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/m_mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: owner codes, FSM states and
// the saturating counter helper used by the starvation logic.
package m_mem_arbiter_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_PTW  = 2'd1;
    localparam logic [1:0] OWN_DATA = 2'd2;
    localparam logic [1:0] OWN_INSN = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Increment a counter but never beyond the given limit.
    function automatic logic [7:0] f_sat_inc(input logic [7:0] cnt, input logic [7:0] lim);
        logic [7:0] nxt;
        if (cnt >= lim) begin
            nxt = lim;
        end else begin
            nxt = cnt + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/m_mem_arbiter.sv
// Three-way DRAM arbiter: page walker, data port and instruction fetch share
// one single-outstanding DRAM port. Fixed priority PTW > data > insn, with a
// starvation counter that lifts instruction fetch above data after MAX_WAIT
// lost arbitrations. One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE.
module m_mem_arbiter
    import m_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        w_ptw_req,
    input  logic        w_ptw_we,
    input  logic [31:0] w_ptw_addr,
    input  logic [31:0] w_ptw_wdata,
    input  logic        w_d_req,
    input  logic        w_d_we,
    input  logic [3:0]  w_d_wmask,
    input  logic [31:0] w_d_addr,
    input  logic [31:0] w_d_wdata,
    input  logic        w_i_req,
    input  logic [31:0] w_i_addr,
    output logic        w_ptw_gnt,
    output logic        w_d_gnt,
    output logic        w_i_gnt,
    output logic        w_ptw_done,
    output logic        w_d_done,
    output logic        w_i_done,
    output logic [31:0] w_rdata,
    output logic        w_dram_ce,
    output logic        w_dram_we,
    output logic [3:0]  w_dram_wmask,
    output logic [31:0] w_dram_addr,
    output logic [31:0] w_dram_wdata,
    input  logic        w_dram_busy,
    input  logic [31:0] w_dram_odata,
    output logic [1:0]  w_owner
);

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    arb_state_t  r_state;
    logic [1:0]  r_owner;
    logic        r_wait_first;
    logic [7:0]  r_starve_cnt;
    logic        r_we;
    logic [3:0]  r_wmask;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_starved;
    logic [1:0]  w_win;
    logic        w_cap_we;
    logic [3:0]  w_cap_wmask;
    logic [31:0] w_cap_addr;
    logic [31:0] w_cap_wdata;

    // Select the arbitration winner and assemble its command fields.
    always_comb begin
        w_starved   = (r_starve_cnt == LP_MAX_WAIT);
        w_win       = OWN_NONE;
        w_cap_we    = 1'b0;
        w_cap_wmask = 4'b0000;
        w_cap_addr  = 32'h0000_0000;
        w_cap_wdata = 32'h0000_0000;
        if (w_ptw_req) begin
            w_win = OWN_PTW;
        end else if (w_i_req && w_starved) begin
            w_win = OWN_INSN;
        end else if (w_d_req) begin
            w_win = OWN_DATA;
        end else if (w_i_req) begin
            w_win = OWN_INSN;
        end else begin
            w_win = OWN_NONE;
        end
        case (w_win)
            OWN_PTW: begin
                // PTE A/D updates always write the whole word.
                w_cap_we    = w_ptw_we;
                w_cap_wmask = w_ptw_we ? 4'b1111 : 4'b0000;
                w_cap_addr  = w_ptw_addr;
                w_cap_wdata = w_ptw_wdata;
            end
            OWN_DATA: begin
                w_cap_we    = w_d_we;
                w_cap_wmask = w_d_wmask;
                w_cap_addr  = w_d_addr;
                w_cap_wdata = w_d_wdata;
            end
            OWN_INSN: begin
                w_cap_we    = 1'b0;
                w_cap_wmask = 4'b0000;
                w_cap_addr  = w_i_addr;
                w_cap_wdata = 32'h0000_0000;
            end
            default: begin
                w_cap_we    = 1'b0;
                w_cap_wmask = 4'b0000;
                w_cap_addr  = 32'h0000_0000;
                w_cap_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Transaction FSM with starvation counter, command capture and read-data latch.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_NONE;
            r_wait_first <= 1'b0;
            r_starve_cnt <= 8'd0;
            r_we         <= 1'b0;
            r_wmask      <= 4'b0000;
            r_addr       <= 32'h0000_0000;
            r_wdata      <= 32'h0000_0000;
            r_rdata      <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win != OWN_NONE) begin
                        r_owner <= w_win;
                        r_we    <= w_cap_we;
                        r_wmask <= w_cap_wmask;
                        r_addr  <= w_cap_addr;
                        r_wdata <= w_cap_wdata;
                        r_state <= ST_ISSUE;
                        if (w_win == OWN_INSN) begin
                            r_starve_cnt <= 8'd0;
                        end else if (w_i_req) begin
                            r_starve_cnt <= f_sat_inc(r_starve_cnt, LP_MAX_WAIT);
                        end
                    end
                end
                ST_ISSUE: begin
                    // The strobe fires combinationally in the cycle busy is low.
                    if (!w_dram_busy) begin
                        r_state      <= ST_WAIT;
                        r_wait_first <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Busy only rises one cycle after ce, so the first WAIT cycle is skipped.
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (!w_dram_busy) begin
                        if (!r_we) begin
                            r_rdata <= w_dram_odata;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_owner <= OWN_NONE;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

    // Owner-based output decode; gnt spans capture through the done cycle.
    always_comb begin
        w_ptw_gnt    = (r_owner == OWN_PTW);
        w_d_gnt      = (r_owner == OWN_DATA);
        w_i_gnt      = (r_owner == OWN_INSN);
        w_ptw_done   = (r_state == ST_DONE) && (r_owner == OWN_PTW);
        w_d_done     = (r_state == ST_DONE) && (r_owner == OWN_DATA);
        w_i_done     = (r_state == ST_DONE) && (r_owner == OWN_INSN);
        w_dram_ce    = (r_state == ST_ISSUE) && !w_dram_busy;
        w_dram_we    = r_we;
        w_dram_wmask = r_wmask;
        w_dram_addr  = r_addr;
        w_dram_wdata = r_wdata;
        w_rdata      = r_rdata;
        w_owner      = r_owner;
    end

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed bench for m_mem_arbiter with a behavioural DRAM whose read data
// is the captured address XOR a per-test key and whose busy length is set per test.
module tb_m_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic        w_ptw_req = 1'b0, w_ptw_we = 1'b0;
    logic [31:0] w_ptw_addr = 32'd0, w_ptw_wdata = 32'd0;
    logic        w_d_req = 1'b0, w_d_we = 1'b0;
    logic [3:0]  w_d_wmask = 4'd0;
    logic [31:0] w_d_addr = 32'd0, w_d_wdata = 32'd0;
    logic        w_i_req = 1'b0;
    logic [31:0] w_i_addr = 32'd0;
    logic        w_ptw_gnt, w_d_gnt, w_i_gnt;
    logic        w_ptw_done, w_d_done, w_i_done;
    logic [31:0] w_rdata;
    logic        w_dram_ce, w_dram_we;
    logic [3:0]  w_dram_wmask;
    logic [31:0] w_dram_addr, w_dram_wdata;
    logic        w_dram_busy;
    logic [31:0] w_dram_odata;
    logic [1:0]  w_owner;

    int n_assert = 0;
    int n_fail = 0;
    int n_viol = 0;
    int n_done_total = 0;

    // DRAM model state
    int          lat = 1;
    int          busy_cnt;
    logic [31:0] rd_key = 32'd0;
    logic [31:0] cap_addr = 32'd0, cap_wdata = 32'd0;
    logic        cap_we = 1'b0;
    logic [3:0]  cap_wmask = 4'd0;

    m_mem_arbiter #(.MAX_WAIT(3)) u_dut (
        .CLK(CLK), .RST_X(RST_X),
        .w_ptw_req(w_ptw_req), .w_ptw_we(w_ptw_we), .w_ptw_addr(w_ptw_addr), .w_ptw_wdata(w_ptw_wdata),
        .w_d_req(w_d_req), .w_d_we(w_d_we), .w_d_wmask(w_d_wmask), .w_d_addr(w_d_addr), .w_d_wdata(w_d_wdata),
        .w_i_req(w_i_req), .w_i_addr(w_i_addr),
        .w_ptw_gnt(w_ptw_gnt), .w_d_gnt(w_d_gnt), .w_i_gnt(w_i_gnt),
        .w_ptw_done(w_ptw_done), .w_d_done(w_d_done), .w_i_done(w_i_done),
        .w_rdata(w_rdata),
        .w_dram_ce(w_dram_ce), .w_dram_we(w_dram_we), .w_dram_wmask(w_dram_wmask),
        .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata),
        .w_dram_busy(w_dram_busy), .w_dram_odata(w_dram_odata),
        .w_owner(w_owner)
    );

    always #5 CLK = ~CLK;

    // Behavioural DRAM: busy rises after ce, stays high lat cycles, then data valid.
    always @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            w_dram_busy  <= 1'b0;
            busy_cnt     <= 0;
            w_dram_odata <= 32'd0;
        end else if (w_dram_ce) begin
            w_dram_busy <= 1'b1;
            busy_cnt    <= lat;
            cap_addr    <= w_dram_addr;
            cap_we      <= w_dram_we;
            cap_wmask   <= w_dram_wmask;
            cap_wdata   <= w_dram_wdata;
        end else if (w_dram_busy) begin
            if (busy_cnt <= 1) begin
                w_dram_busy  <= 1'b0;
                w_dram_odata <= cap_addr ^ rd_key;
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    // Exclusivity monitor: one gnt, one done, ce only while someone owns the port.
    always @(negedge CLK) begin
        if (RST_X) begin
            if ((32'(w_ptw_gnt) + 32'(w_d_gnt) + 32'(w_i_gnt)) > 32'd1) n_viol++;
            if ((32'(w_ptw_done) + 32'(w_d_done) + 32'(w_i_done)) > 32'd1) n_viol++;
            if (w_dram_ce && !(w_ptw_gnt || w_d_gnt || w_i_gnt)) n_viol++;
            if (w_ptw_done || w_d_done || w_i_done) n_done_total++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Wait (bounded) for any done pulse; who=0 on timeout.
    task automatic wait_done(output logic [1:0] who, output int cyc);
        who = 2'd0;
        cyc = 0;
        while (who == 2'd0 && cyc < 40) begin
            @(posedge CLK); #1;
            cyc++;
            if (w_ptw_done)     who = 2'd1;
            else if (w_d_done)  who = 2'd2;
            else if (w_i_done)  who = 2'd3;
        end
    endtask

    // The cycle after done: port released and the pulse gone.
    task automatic check_release(input string tag);
        @(posedge CLK); #1;
        check_eq({tag, "_owner0"}, 32'(w_owner), 32'd0);
        check_eq({tag, "_done_low"}, 32'({w_ptw_done, w_d_done, w_i_done}), 32'd0);
    endtask

    initial begin
        logic [1:0]  who;
        int          cyc;
        logic [1:0]  exp_who;
        logic [31:0] exp_rd;
        int          done_before;

        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_owner", 32'(w_owner), 32'd0);
        check_eq("rst_gnt", 32'({w_ptw_gnt, w_d_gnt, w_i_gnt}), 32'd0);
        check_eq("rst_rdata", w_rdata, 32'd0);
        check_eq("rst_ce_we", 32'({w_dram_ce, w_dram_we}), 32'd0);
        @(negedge CLK);
        RST_X = 1'b1;
        @(posedge CLK); #1;

        // PTW read with 3 busy cycles
        lat = 3;
        rd_key = 32'h2000_00CF ^ 32'h8000_1004;
        w_ptw_req = 1'b1; w_ptw_we = 1'b0; w_ptw_addr = 32'h8000_1004;
        wait_done(who, cyc);
        w_ptw_req = 1'b0;
        check_eq("ptw_rd_who", 32'(who), 32'd1);
        check_eq("ptw_rd_cycles", 32'(cyc), 32'd6);
        check_eq("ptw_rd_rdata", w_rdata, 32'h2000_00CF);
        check_eq("ptw_rd_addr", cap_addr, 32'h8000_1004);
        check_eq("ptw_rd_we", 32'(cap_we), 32'd0);
        check_release("ptw_rd");
        check_eq("ptw_rd_rdata_hold", w_rdata, 32'h2000_00CF);

        // Minimum latency: zero DRAM wait gives capture-to-done of 4 cycles
        lat = 1;
        rd_key = 32'd0;
        w_d_req = 1'b1; w_d_we = 1'b0; w_d_wmask = 4'hF; w_d_addr = 32'h1000_0010;
        wait_done(who, cyc);
        w_d_req = 1'b0;
        check_eq("min_lat_who", 32'(who), 32'd2);
        check_eq("min_lat_cycles", 32'(cyc), 32'd4);
        check_eq("min_lat_rdata", w_rdata, 32'h1000_0010);
        check_release("min_lat");

        // All three at once: PTW, then data, then insn
        w_ptw_req = 1'b1; w_ptw_we = 1'b0; w_ptw_addr = 32'h8000_3000;
        w_d_req = 1'b1; w_d_addr = 32'h1000_0040;
        w_i_req = 1'b1; w_i_addr = 32'h0000_1000;
        for (int k = 0; k < 3; k++) begin
            wait_done(who, cyc);
            exp_who = (k == 0) ? 2'd1 : ((k == 1) ? 2'd2 : 2'd3);
            exp_rd  = (k == 0) ? 32'h8000_3000 : ((k == 1) ? 32'h1000_0040 : 32'h0000_1000);
            check_eq("all3_order", 32'(who), 32'(exp_who));
            check_eq("all3_rdata", w_rdata, exp_rd);
            if (who == 2'd1) w_ptw_req = 1'b0;
            else if (who == 2'd2) w_d_req = 1'b0;
            else if (who == 2'd3) w_i_req = 1'b0;
            else begin
                w_ptw_req = 1'b0; w_d_req = 1'b0; w_i_req = 1'b0;
            end
            check_release("all3");
        end

        // Starvation: data and insn both held, insn wins the 4th arbitration
        w_d_req = 1'b1; w_d_addr = 32'h1000_0080;
        w_i_req = 1'b1; w_i_addr = 32'h0000_2000;
        for (int k = 0; k < 5; k++) begin
            wait_done(who, cyc);
            exp_who = (k == 3) ? 2'd3 : 2'd2;
            exp_rd  = (k == 3) ? 32'h0000_2000 : 32'h1000_0080;
            check_eq("starve_order", 32'(who), 32'(exp_who));
            check_eq("starve_rdata", w_rdata, exp_rd);
            if (k == 4) begin
                w_d_req = 1'b0; w_i_req = 1'b0;
            end
            check_release("starve");
        end

        // PTW write: full mask, read data untouched
        w_ptw_req = 1'b1; w_ptw_we = 1'b1; w_ptw_addr = 32'h8000_2008; w_ptw_wdata = 32'h0000_00C7;
        wait_done(who, cyc);
        w_ptw_req = 1'b0; w_ptw_we = 1'b0;
        check_eq("ptw_wr_who", 32'(who), 32'd1);
        check_eq("ptw_wr_we", 32'(cap_we), 32'd1);
        check_eq("ptw_wr_wmask", 32'(cap_wmask), 32'hF);
        check_eq("ptw_wr_addr", cap_addr, 32'h8000_2008);
        check_eq("ptw_wr_wdata", cap_wdata, 32'h0000_00C7);
        check_eq("ptw_wr_rdata", w_rdata, 32'h1000_0080);
        check_release("ptw_wr");

        // Data partial write: mask passes through, read data untouched
        w_d_req = 1'b1; w_d_we = 1'b1; w_d_wmask = 4'b0110; w_d_addr = 32'h1000_0100; w_d_wdata = 32'hDEAD_BEEF;
        wait_done(who, cyc);
        w_d_req = 1'b0; w_d_we = 1'b0;
        check_eq("d_wr_who", 32'(who), 32'd2);
        check_eq("d_wr_wmask", 32'(cap_wmask), 32'h6);
        check_eq("d_wr_wdata", cap_wdata, 32'hDEAD_BEEF);
        check_eq("d_wr_rdata", w_rdata, 32'h1000_0080);
        check_release("d_wr");

        // Reset during WAIT: abandon, then the still-pending data read is served
        lat = 5;
        rd_key = 32'h0000_FFFF;
        w_d_req = 1'b1; w_d_wmask = 4'hF; w_d_addr = 32'h1000_0200;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("mid_rst_gnt_before", 32'(w_d_gnt), 32'd1);
        done_before = n_done_total;
        RST_X = 1'b0;
        #1;
        check_eq("mid_rst_owner", 32'(w_owner), 32'd0);
        check_eq("mid_rst_gnt", 32'({w_ptw_gnt, w_d_gnt, w_i_gnt}), 32'd0);
        check_eq("mid_rst_rdata", w_rdata, 32'd0);
        check_eq("mid_rst_addr", w_dram_addr, 32'd0);
        check_eq("mid_rst_ce_we", 32'({w_dram_ce, w_dram_we}), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_X = 1'b1;
        check_eq("mid_rst_no_done", 32'(n_done_total), 32'(done_before));
        wait_done(who, cyc);
        w_d_req = 1'b0;
        check_eq("post_rst_who", 32'(who), 32'd2);
        check_eq("post_rst_rdata", w_rdata, 32'h1000_0200 ^ 32'h0000_FFFF);
        check_release("post_rst");

        repeat (2) @(posedge CLK);
        #1;
        check_eq("exclusive_viol", 32'(n_viol), 32'd0);
        check_eq("done_total", 32'(n_done_total), 32'd13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
